fir_engine_v2: RTL
==================

// Module: fir_engine_v2
// PURPOSE
//  Second-generation streaming FIR: programmable tap count (1..pMAX_TAPS), internal coefficient/history
//  register files, sequential signed MAC (one tap/cycle). AXI-Lite config/status, AXI-Stream x[n] in,
//  y[n] out. Sits between the DMA stream ports and the user-project AXI-Lite decoder.
// PARAMETERS
//  pADDR_WIDTH  12  AXI-Lite address width
//  pDATA_WIDTH  32  sample/coefficient/register width (signed two's complement)
//  pMAX_TAPS    32  coefficient and history depth (power of 2, <=64)
//  pACC_WIDTH   72  accumulator width (>= 2*pDATA_WIDTH + clog2(pMAX_TAPS))
//  pOUT_SHIFT   0   arithmetic right shift applied to accumulator before output
// PORTS
//  axis_clk   in  1            single clock
//  axis_rst   in  1            synchronous reset, active-high
//  awvalid    in  1            write address valid
//  awready    out 1            write address accepted
//  awaddr     in  pADDR_WIDTH  write address
//  wvalid     in  1            write data valid
//  wready     out 1            write data accepted
//  wdata      in  pDATA_WIDTH  write data
//  arvalid    in  1            read address valid
//  arready    out 1            read address accepted
//  araddr     in  pADDR_WIDTH  read address
//  rvalid     out 1            read data valid
//  rready     in  1            read data accepted
//  rdata      out pDATA_WIDTH  read data
//  ss_tvalid  in  1            input sample valid
//  ss_tready  out 1            input sample accepted
//  ss_tdata   in  pDATA_WIDTH  input sample x[n]
//  sm_tvalid  out 1            output sample valid
//  sm_tready  in  1            output sample accepted
//  sm_tdata   out pDATA_WIDTH  output sample y[n]
//  sm_tlast   out 1            marks y[data_length-1]
// BEHAVIOUR
//  Reset: all outputs 0; ap_idle=1, ap_done=0, data_length=0, tap_num=1, coefs/history=0, FSM=IDLE.
//  Regs: 0x00 ctrl {ap_idle[2] RO, ap_done[1] RO clear-on-read, ap_start[0] W1 self-clear};
//   0x10 data_length; 0x14 tap_num (write clamped to 1..pMAX_TAPS); 0x80+4*i coef[i], i<pMAX_TAPS.
//   Unmapped reads return 0; unmapped writes dropped. 0x10/0x14/coef writes ignored when ap_idle=0.
//  AXI-Lite write: awready=wready=awvalid&wvalid (both channels in same cycle); reg updates next edge.
//  AXI-Lite read: arready=arvalid&!rvalid; rdata registered, rvalid next cycle, held until rready.
//  ap_done read-clear on the rvalid&rready beat; a same-cycle done-set wins.
//  FSM: IDLE -start&ap_idle-> CLR (tap_num cycles zeroing history, ap_idle=0, ap_start reads 1)
//   -> WAIT_IN (ss_tready=1) -handshake: x stored at head, head++ mod pMAX_TAPS-> MAC (tap_num cycles,
//   acc+=coef[i]*hist[head-1-i], signed) -> OUT (sm_tvalid=1 held, sm_tdata stable) -sm_tready->
//   WAIT_IN, or IDLE with ap_done=1, ap_idle=1 when output count reaches data_length.
//  data_length=0: CLR -> IDLE, ap_done=1, no stream traffic. ss_tready=0 in every state but WAIT_IN.
//  Latency: ss handshake edge -> sm_tvalid high after tap_num+1 cycles; throughput 1 per tap_num+2.
//  Output: y = acc >>> pOUT_SHIFT, low pDATA_WIDTH bits (wrap). sm_tlast=1 only with final y.
//  ap_start written while busy: ignored. axis_rst mid-frame: immediate return to reset state.
// CONFIGURATION
//  FIR_SAT_EN defined: shifted acc saturated to [-2^(pDATA_WIDTH-1), 2^(pDATA_WIDTH-1)-1] and
//   sticky bit ctrl[4] set on any clip (cleared on ap_start). Undefined: wrap; ctrl[4] reads 0.
// TESTING
//  Reg access: write 0x14=40 (pMAX_TAPS=32) -> read 0x14=32; read 0x2C -> 0; ctrl after reset -> 0x4.
//  Impulse: tap_num=4, coef={1,2,3,4}, len=6, x={1,0,0,0,0,0} -> y={1,2,3,4,0,0}, tlast on 6th.
//  Golden: tap_num=11, coef={0,-10,-9,23,56,63,56,23,-9,-10,0}, len=64, x=0..63 -> matches model.
//  Backpressure: sm_tready low 5 cycles in OUT -> sm_tdata stable, ss_tready=0 until accepted.
//  Restart: second start after done, same cfg -> identical y (history cleared); ap_done 1 then 0 on read.
//  Overflow: tap_num=2, coef={0x7FFFFFFF,0x7FFFFFFF}, x={0x7FFFFFFF,..} -> FIR_SAT_EN: y=0x7FFFFFFF, ctrl[4]=1.

Source files
------------

// File: rtl/fir_engine_v2.sv
// Streaming FIR with AXI-Lite config and AXI-Stream data, sequential signed MAC (one tap/cycle).
// Optional `FIR_SAT_EN: saturate outputs to pDATA_WIDTH and expose a sticky clip flag at ctrl[4].
module fir_engine_v2 #(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned pMAX_TAPS   = 32,
  parameter int unsigned pACC_WIDTH  = 72,
  parameter int unsigned pOUT_SHIFT  = 0
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  input  logic                   ss_tvalid,
  output logic                   ss_tready,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  output logic                   sm_tvalid,
  input  logic                   sm_tready,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast
);

  localparam int unsigned TW = $clog2(pMAX_TAPS);
  localparam int unsigned DW = pDATA_WIDTH;
  localparam logic [pADDR_WIDTH-1:0] AddrCtrl = pADDR_WIDTH'('h00);
  localparam logic [pADDR_WIDTH-1:0] AddrLen  = pADDR_WIDTH'('h10);
  localparam logic [pADDR_WIDTH-1:0] AddrTap  = pADDR_WIDTH'('h14);
  localparam logic [pADDR_WIDTH-1:0] CoefBase = pADDR_WIDTH'('h80);
  localparam logic [pADDR_WIDTH-1:0] CoefEnd  = pADDR_WIDTH'(128 + 4 * pMAX_TAPS);

  typedef enum logic [2:0] {StIdle, StClr, StWaitIn, StMac, StOut} state_e;

  state_e                 state_q, state_d;
  logic [DW-1:0]          data_length_q, out_cnt_q;
  logic [TW:0]            tap_num_q, tap_wr;
  logic signed [DW-1:0]   coef_q [pMAX_TAPS];
  logic signed [DW-1:0]   hist_q [pMAX_TAPS];
  logic [TW-1:0]          head_q, cnt_q, hist_idx;
  logic signed [pACC_WIDTH-1:0] acc_q, acc_sh;
  logic signed [2*DW-1:0] prod;
  logic                   ap_done_q, rvalid_q, rd_ctrl_q;
  logic [DW-1:0]          rdata_q, rd_val;
  logic                   ap_idle, wr_en, cfg_wr, start, cnt_last, last_out, fin, sat_flag;

  function automatic logic coef_hit(input logic [pADDR_WIDTH-1:0] a);
    return (a[1:0] == 2'b00) && (a >= CoefBase) && (a < CoefEnd);
  endfunction

  function automatic logic [TW-1:0] coef_idx(input logic [pADDR_WIDTH-1:0] a);
    return TW'((a - CoefBase) >> 2);
  endfunction

  assign ap_idle  = (state_q == StIdle);
  assign wr_en    = awvalid & wvalid;
  assign awready  = wr_en;
  assign wready   = wr_en;
  assign cfg_wr   = wr_en & ap_idle;
  assign start    = cfg_wr && (awaddr == AddrCtrl) && wdata[0];
  assign cnt_last = ({1'b0, cnt_q} == tap_num_q - {{TW{1'b0}}, 1'b1});
  assign last_out = (out_cnt_q == data_length_q - {{(DW-1){1'b0}}, 1'b1});
  assign hist_idx = head_q - cnt_q - TW'(1);
  assign prod     = coef_q[cnt_q] * hist_q[hist_idx];
  assign acc_sh   = acc_q >>> pOUT_SHIFT;
  assign arready  = arvalid & ~rvalid_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign sm_tlast = (state_q == StOut) && last_out;

`ifdef FIR_SAT_EN
  logic sat_q, fits;
  assign fits     = (&acc_sh[pACC_WIDTH-1:DW-1]) || ~(|acc_sh[pACC_WIDTH-1:DW-1]);
  assign sat_flag = sat_q;
  assign sm_tdata = fits ? acc_sh[DW-1:0] :
                    acc_sh[pACC_WIDTH-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};

  always_ff @(posedge axis_clk) begin
    if (axis_rst) sat_q <= 1'b0;
    else if (start) sat_q <= 1'b0;
    else if (state_q == StOut && !fits) sat_q <= 1'b1;
  end
`else
  assign sat_flag = 1'b0;
  assign sm_tdata = DW'(acc_sh);
`endif

  // Out-of-range tap counts clamp rather than wrap.
  always_comb begin
    tap_wr = wdata[TW:0];
    if (wdata == '0) tap_wr = {{TW{1'b0}}, 1'b1};
    else if (wdata > DW'(pMAX_TAPS)) tap_wr = (TW + 1)'(pMAX_TAPS);
  end

  always_comb begin
    rd_val = '0;
    if (araddr == AddrCtrl) begin
      rd_val[0] = (state_q == StClr);
      rd_val[1] = ap_done_q;
      rd_val[2] = ap_idle;
      rd_val[4] = sat_flag;
    end else if (araddr == AddrLen) begin
      rd_val = data_length_q;
    end else if (araddr == AddrTap) begin
      rd_val = DW'(tap_num_q);
    end else if (coef_hit(araddr)) begin
      rd_val = coef_q[coef_idx(araddr)];
    end
  end

  always_comb begin
    state_d   = state_q;
    ss_tready = 1'b0;
    sm_tvalid = 1'b0;
    fin       = 1'b0;
    unique case (state_q)
      StIdle:   if (start) state_d = StClr;
      StClr: begin
        if (cnt_last) begin
          fin     = (data_length_q == '0);
          state_d = fin ? StIdle : StWaitIn;
        end
      end
      StWaitIn: begin
        ss_tready = 1'b1;
        if (ss_tvalid) state_d = StMac;
      end
      StMac:    if (cnt_last) state_d = StOut;
      StOut: begin
        sm_tvalid = 1'b1;
        if (sm_tready) begin
          fin     = last_out;
          state_d = last_out ? StIdle : StWaitIn;
        end
      end
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state_q       <= StIdle;
      data_length_q <= '0;
      tap_num_q     <= {{TW{1'b0}}, 1'b1};
      out_cnt_q     <= '0;
      head_q        <= '0;
      cnt_q         <= '0;
      acc_q         <= '0;
      ap_done_q     <= 1'b0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
      rd_ctrl_q     <= 1'b0;
      for (int i = 0; i < pMAX_TAPS; i++) begin
        coef_q[i] <= '0;
        hist_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (cfg_wr && awaddr == AddrLen) data_length_q <= wdata;
      if (cfg_wr && awaddr == AddrTap) tap_num_q <= tap_wr;
      if (cfg_wr && coef_hit(awaddr)) coef_q[coef_idx(awaddr)] <= wdata;
      if (start) begin
        cnt_q     <= '0;
        head_q    <= '0;
        out_cnt_q <= '0;
      end
      case (state_q)
        StClr: begin
          // Clear exactly the slots the first tap_num outputs will read (head starts at 0).
          hist_q[~cnt_q] <= '0;
          cnt_q          <= cnt_last ? '0 : cnt_q + TW'(1);
        end
        StWaitIn: begin
          if (ss_tvalid) begin
            hist_q[head_q] <= ss_tdata;
            head_q         <= head_q + TW'(1);
            acc_q          <= '0;
            cnt_q          <= '0;
          end
        end
        StMac: begin
          acc_q <= acc_q + pACC_WIDTH'(prod);
          cnt_q <= cnt_last ? '0 : cnt_q + TW'(1);
        end
        StOut:   if (sm_tready) out_cnt_q <= out_cnt_q + DW'(1);
        default: ;
      endcase
      if (fin) ap_done_q <= 1'b1;
      else if (rvalid_q && rready && rd_ctrl_q) ap_done_q <= 1'b0;
      if (rvalid_q && rready) rvalid_q <= 1'b0;
      if (arvalid && !rvalid_q) begin
        rvalid_q  <= 1'b1;
        rdata_q   <= rd_val;
        rd_ctrl_q <= (araddr == AddrCtrl);
      end
    end
  end

endmodule
